display_scan_scheduler: RTL

// Sequences the 4-digit multiplexed 7-seg display and shares it between two content requesters.

---
 rtl/display_scan_scheduler.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/display_scan_scheduler.sv
// display_scan_scheduler: 4-digit multiplexed 7-seg scan with two-source frame arbitration.
// Optional feature macro: LEADING_ZERO_BLANK_EN (keeps leading zero digits dark).
module display_scan_scheduler #(
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_CYC   = 500,
  parameter int HOLD_FRAMES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        src0_req,
  input  logic [15:0] src0_data,
  input  logic        src1_req,
  input  logic [15:0] src1_data,
  output logic [1:0]  grant,
  output logic [3:0]  anode,
  output logic [3:0]  digit,
  output logic [1:0]  an,
  output logic        frame_start
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int HW = $clog2(HOLD_FRAMES + 1) + 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);
  localparam logic [HW-1:0] HOLD      = HW'(HOLD_FRAMES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    an_q, an_d;
  state_e        state_q, state_d;
  logic [HW-1:0] held_q, held_d;
  logic [15:0]   frame_buf_q, frame_buf_d;

  logic          frame_end;
  logic          own_req;
  logic          oth_req;
  logic [HW-1:0] done;
  logic [3:0]    nib;
  logic          suppress;

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      an_q        <= '0;
      state_q     <= IDLE;
      held_q      <= '0;
      frame_buf_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      an_q        <= an_d;
      state_q     <= state_d;
      held_q      <= held_d;
      frame_buf_q <= frame_buf_d;
    end
  end

  // Slot timer: cnt wraps every REFRESH_DIV cycles, advancing the slot index.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    an_d  = an_q;
    if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      an_d  = an_q + 2'd1;
    end
  end

  assign frame_end = (cnt_q == CNT_MAX) && (an_q == 2'd3);

  // Arbiter: ownership and frame latch only change in the frame-end cycle.
  always_comb begin
    state_d     = state_q;
    held_d      = held_q;
    frame_buf_d = frame_buf_q;
    own_req     = 1'b0;
    oth_req     = 1'b0;
    done        = held_q + 1'b1;
    unique case (state_q)
      OWN0: begin
        own_req = src0_req;
        oth_req = src1_req;
      end
      OWN1: begin
        own_req = src1_req;
        oth_req = src0_req;
      end
      default: ;
    endcase
    if (frame_end) begin
      if (!own_req) begin
        held_d = '0;
        if (src1_req) begin
          state_d = OWN1;
        end else if (src0_req) begin
          state_d = OWN0;
        end else begin
          state_d = IDLE;
        end
      end else if ((done >= HOLD) && oth_req) begin
        held_d  = '0;
        state_d = (state_q == OWN0) ? OWN1 : OWN0;
      end else begin
        held_d = (done > HOLD) ? HOLD : done;
      end
      unique case (state_d)
        OWN0:    frame_buf_d = src0_data;
        OWN1:    frame_buf_d = src1_data;
        default: frame_buf_d = '0;
      endcase
    end
  end

  assign nib = frame_buf_q[{~an_q, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
  logic [15:0] lead;
  assign lead = frame_buf_q >> {~an_q, 2'b00};
  // Current nibble and everything left of it zero means a leading zero.
  assign suppress = (an_q != 2'd3) && (lead == 16'd0);
`else
  assign suppress = 1'b0;
`endif

  // Output decode from registered state only.
  always_comb begin
    grant       = {state_q == OWN1, state_q == OWN0};
    an          = an_q;
    frame_start = (cnt_q == '0) && (an_q == 2'd0);
    digit       = '0;
    anode       = 4'b1111;
    if (state_q != IDLE) begin
      digit = nib;
      if ((cnt_q >= BLANK_END) && !suppress) begin
        unique case (an_q)
          2'd0:    anode = 4'b0111;
          2'd1:    anode = 4'b1011;
          2'd2:    anode = 4'b1101;
          default: anode = 4'b1110;
        endcase
      end
    end
  end

endmodule
